// File: rtl/ysyx_22050243_pkg.sv
// Shared definitions for the ysyx_22050243 core front end.
// Contents: the default reset PC, the fetch FSM state encoding, the nop
// used as the idle instruction word, the RV64I major-opcode constants and
// a word-alignment helper.
package ysyx_22050243_pkg;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Instructions are 32-bit aligned; the low two address bits are dropped.
  function automatic logic [63:0] align4(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22050243_pc_reg.sv
// Fetch PC register.
// Ports:
//   clk, rst        clock, async active-high reset (loads RESET_PC)
//   advance         step to the next sequential instruction (pc + 4)
//   redirect_valid  load redirect_pc instead; wins over advance
//   redirect_pc     new target, low two bits dropped
//   pc              current fetch address, always word aligned
module ysyx_22050243_pc_reg #(
  parameter logic [63:0] RESET_PC = ysyx_22050243_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc
);
  import ysyx_22050243_pkg::*;

  // pc + 4 wraps naturally at 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= align4(RESET_PC);
    else if (redirect_valid) pc <= align4(redirect_pc);
    else if (advance)        pc <= pc + 64'd4;
  end

endmodule

// File: rtl/ysyx_22050243_ifu.sv
// Instruction fetch unit: one outstanding request at a time, a single
// instruction holding register toward decode, and redirect handling that
// discards any response belonging to a superseded fetch.
// Ports:
//   clk, rst                          clock, async active-high reset
//   imem_req_valid/ready/addr         fetch request handshake
//   imem_resp_valid/data              returned instruction (only used in WAIT)
//   redirect_valid/redirect_pc        new PC from the branch/jump unit
//   id_valid/id_ready                 decode handshake
//   id_inst/id_pc/id_opcode/id_funct3 held instruction, its PC and decode slices
module ysyx_22050243_ifu #(
  parameter logic [63:0] RESET_PC = ysyx_22050243_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3
);
  import ysyx_22050243_pkg::*;

  fetch_state_e state, state_nxt;
  logic         kill, kill_nxt;
  logic         capture;
  logic         advance;
  logic [63:0]  pc;

  ysyx_22050243_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  // Redirect priority over pc+4 lives in the pc register.
  assign advance = (state == HOLD) && id_ready;

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    capture   = 1'b0;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_nxt = WAIT;
          // Request went out with the old pc; its response must be dropped.
          kill_nxt  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_nxt = REQ;
          kill_nxt  = 1'b0;
          if (!kill && !redirect_valid) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          kill_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (id_ready || redirect_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      kill    <= 1'b0;
      id_inst <= NOP_INST;
      id_pc   <= 64'h0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      if (capture) begin
        id_inst <= imem_resp_data;
        id_pc   <= pc;
      end
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign id_valid       = (state == HOLD);
  assign id_opcode      = id_inst[6:0];
  assign id_funct3      = id_inst[14:12];

endmodule

// File: tb/tb_ysyx_22050243_ifu.sv
module tb_ysyx_22050243_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;

  ysyx_22050243_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_inst         (id_inst),
    .id_pc           (id_pc),
    .id_opcode       (id_opcode),
    .id_funct3       (id_funct3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic quiet_inputs;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    id_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'h0;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    quiet_inputs();
    tick();
    chk("reset id_valid", id_valid, 0);
    chk("reset req_valid", imem_req_valid, 0);
    chk("reset id_inst", id_inst, 32'h13);
    chk("reset id_pc", id_pc, 0);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        resp_v;
    logic [31:0] data;
    logic        idr;
    logic        rdv;
    logic [63:0] rdpc;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_idv;
    logic [63:0] e_pc;
    logic [6:0]  e_opc;
    logic [2:0]  e_f3;
  } vec_t;

  vec_t vt [10];

  // random-phase reference: transaction-level view of the fetch stream
  logic [63:0] exp_pc;
  logic        out_v, out_kill;
  int          out_delay;
  logic [63:0] out_addr;
  logic        pend_v;
  logic [63:0] pend_addr;
  logic [31:0] pend_data;
  logic        first;
  int          delivered;
  int          acc;
  logic [63:0] r;

  initial begin
    // zero-wait fetch of two instructions from reset
    vt[0] = '{0, 0, 32'h0,        0, 0, 64'h0, 0, 64'h0,         0, 64'h0,         7'h00, 3'd0};
    vt[1] = '{1, 0, 32'h0,        0, 0, 64'h0, 1, 64'h8000_0000, 0, 64'h0,         7'h00, 3'd0};
    vt[2] = '{0, 1, 32'h00000513, 0, 0, 64'h0, 0, 64'h0,         0, 64'h0,         7'h00, 3'd0};
    vt[3] = '{0, 0, 32'h0,        1, 0, 64'h0, 0, 64'h0,         1, 64'h8000_0000, 7'h13, 3'd0};
    vt[4] = '{0, 0, 32'h0,        0, 0, 64'h0, 1, 64'h8000_0004, 0, 64'h0,         7'h00, 3'd0};
    vt[5] = '{1, 0, 32'h0,        0, 0, 64'h0, 1, 64'h8000_0004, 0, 64'h0,         7'h00, 3'd0};
    vt[6] = '{0, 1, 32'h0002A283, 0, 0, 64'h0, 0, 64'h0,         0, 64'h0,         7'h00, 3'd0};
    vt[7] = '{0, 0, 32'h0,        0, 0, 64'h0, 0, 64'h0,         1, 64'h8000_0004, 7'h03, 3'd2};
    vt[8] = '{0, 0, 32'h0,        1, 0, 64'h0, 0, 64'h0,         1, 64'h8000_0004, 7'h03, 3'd2};
    vt[9] = '{0, 0, 32'h0,        0, 0, 64'h0, 1, 64'h8000_0008, 0, 64'h0,         7'h00, 3'd0};

    rst = 1'b1;
    quiet_inputs();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      imem_req_ready  = vt[i].ready;
      imem_resp_valid = vt[i].resp_v;
      imem_resp_data  = vt[i].data;
      id_ready        = vt[i].idr;
      redirect_valid  = vt[i].rdv;
      redirect_pc     = vt[i].rdpc;
      chk($sformatf("vec%0d req_valid", i), imem_req_valid, vt[i].e_req);
      if (vt[i].e_req) chk($sformatf("vec%0d req_addr", i), imem_req_addr, vt[i].e_addr);
      chk($sformatf("vec%0d id_valid", i), id_valid, vt[i].e_idv);
      if (vt[i].e_idv) begin
        chk($sformatf("vec%0d id_pc", i), id_pc, vt[i].e_pc);
        chk($sformatf("vec%0d id_opcode", i), id_opcode, vt[i].e_opc);
        chk($sformatf("vec%0d id_funct3", i), id_funct3, vt[i].e_f3);
      end
      tick();
    end

    // request stalled by imem_req_ready low for 5 cycles
    do_reset();
    tick();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      imem_req_ready = (i >= 5);
      if (i <= 5) chk("stall addr", imem_req_addr, 64'h8000_0000);
      if (imem_req_valid && imem_req_ready) acc++;
      tick();
    end
    quiet_inputs();
    chk("stall accepts", acc, 1);

    // redirect while waiting kills the response
    do_reset();
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    tick();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    chk("wait-redir id_valid0", id_valid, 0);
    tick();
    imem_resp_valid = 1'b0;
    chk("wait-redir id_valid1", id_valid, 0);
    chk("wait-redir req_valid", imem_req_valid, 1);
    chk("wait-redir addr", imem_req_addr, 64'h8000_1000);

    // HOLD stability, then id_ready + redirect together
    do_reset();
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0002A283;
    tick();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold id_valid", id_valid, 1);
      chk("hold id_inst", id_inst, 32'h0002A283);
      chk("hold id_pc", id_pc, 64'h8000_0000);
      tick();
    end
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    quiet_inputs();
    chk("hold-redir id_valid", id_valid, 0);
    chk("hold-redir req_valid", imem_req_valid, 1);
    chk("hold-redir addr", imem_req_addr, 64'h8000_0100);

    // reset in the middle of WAIT, late response ignored
    do_reset();
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h00000513;
    tick();
    imem_resp_valid = 1'b0;
    id_ready        = 1'b1;
    tick();
    id_ready       = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst id_valid", id_valid, 0);
    chk("midrst id_inst", id_inst, 32'h13);
    chk("midrst id_pc", id_pc, 0);
    chk("midrst req_valid", imem_req_valid, 0);
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    chk("midrst restart req", imem_req_valid, 1);
    chk("midrst restart addr", imem_req_addr, 64'h8000_0000);
    chk("midrst late id_valid", id_valid, 0);
    chk("midrst late id_inst", id_inst, 32'h13);

    // wrap from the top of the address space
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    chk("wrap old addr", imem_req_addr, 64'h8000_0000);
    tick();
    redirect_valid = 1'b0;
    chk("wrap new addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h00000013;
    tick();
    imem_resp_valid = 1'b0;
    chk("wrap id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("wrap req_valid", imem_req_valid, 1);
    chk("wrap addr", imem_req_addr, 64'h0);

    // randomized traffic against a transaction-level model
    do_reset();
    exp_pc    = 64'h8000_0000;
    out_v     = 1'b0;
    out_kill  = 1'b0;
    out_delay = 0;
    out_addr  = 64'h0;
    pend_v    = 1'b0;
    pend_addr = 64'h0;
    pend_data = 32'h0;
    first     = 1'b1;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd id_valid", id_valid, pend_v);
      if (pend_v) begin
        chk("rnd id_inst", id_inst, pend_data);
        chk("rnd id_pc", id_pc, pend_addr);
        chk("rnd id_opcode", id_opcode, pend_data[6:0]);
        chk("rnd id_funct3", id_funct3, pend_data[14:12]);
      end
      chk("rnd req_valid", imem_req_valid, !first && !out_v && !pend_v);

      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      r = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) r[63:8] = '1;
      redirect_pc = r;
      if (out_v && out_delay == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = $urandom;
      end else if (!out_v && $urandom_range(0, 9) == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = $urandom;
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end

      // what the coming edge does to the fetch stream
      if (pend_v && id_ready) begin
        delivered++;
        pend_v = 1'b0;
        if (!redirect_valid) exp_pc = exp_pc + 64'd4;
      end
      if (out_v) begin
        if (imem_resp_valid) begin
          if (!out_kill && !redirect_valid) begin
            pend_v    = 1'b1;
            pend_addr = out_addr;
            pend_data = imem_resp_data;
          end
          out_v = 1'b0;
        end else begin
          out_delay--;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("rnd req_addr", imem_req_addr, exp_pc);
        out_v     = 1'b1;
        out_kill  = 1'b0;
        out_addr  = exp_pc;
        out_delay = $urandom_range(0, 2);
      end
      if (redirect_valid) begin
        exp_pc = r & ~64'h3;
        if (out_v) out_kill = 1'b1;
        pend_v = 1'b0;
      end
      first = 1'b0;
      tick();
    end
    quiet_inputs();
    chk("rnd deliveries", (delivered > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
